// File: rtl/thread_pc_fetch_pkg.sv
// Shared types and constants for the 4-thread fetch front end.
// Also carries the fetch tag that travels into decode.
package thread_pc_fetch_pkg;

  localparam int NTHREADS = 4;
  localparam int TID_W    = 2;
  localparam int PC_W_DEF = 9;

  typedef logic [TID_W-1:0] tid_t;

  typedef struct packed {
    logic                valid;
    tid_t                tid;
    logic [PC_W_DEF-1:0] pc;
  } fetch_tag_t;

  function automatic logic [PC_W_DEF-1:0] base_pc(input int unsigned t);
    logic [PC_W_DEF-1:0] tv;
    tv = PC_W_DEF'(t);
    return tv << (PC_W_DEF - 2);
  endfunction

endpackage

// File: rtl/thread_pc_fetch_pc_reg.sv
// Single-thread PC register with load/increment/hold and a sticky halt bit.
// The caller guarantees load and inc are never both set.
module thread_pc_reg
  import thread_pc_fetch_pkg::*;
#(
  parameter int              PC_W   = PC_W_DEF,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_pc_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o
);

  logic [PC_W-1:0] pc_d, pc_q;
  logic            halted_d, halted_q;

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q | halt_i;
    unique case (1'b1)
      load_i:  pc_d = load_pc_i;
      inc_i:   pc_d = pc_q + 1'b1;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RST_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc_o     = pc_q;
  assign halted_o = halted_q;

endmodule

// File: rtl/thread_pc_fetch.sv
// Per-thread PC file and fetch-address stage; registers the tag
// that lines up with the synchronous instruction memory output.
module thread_pc_fetch
  import thread_pc_fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int NTHREADS_P = NTHREADS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [TID_W-1:0]    tid_in,
  input  logic [NTHREADS-1:0] thread_en,
  input  logic                redirect_valid,
  input  logic [TID_W-1:0]    redirect_tid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                halt_valid,
  input  logic [TID_W-1:0]    halt_tid,
  output logic [PC_W-1:0]     imem_addr,
  output logic                if_valid,
  output logic [TID_W-1:0]    if_tid,
  output logic [PC_W-1:0]     if_pc,
  output logic [NTHREADS-1:0] halted,
  output logic                all_halted
);

  logic [PC_W-1:0]     pc_q [NTHREADS];
  logic [NTHREADS-1:0] halted_w;
  logic [NTHREADS-1:0] act, sel, kill, hlt;
  logic [NTHREADS-1:0] load, inc;

  logic                if_valid_d, if_valid_q;
  logic [TID_W-1:0]    if_tid_q;
  logic [PC_W-1:0]     if_pc_q;

  for (genvar t = 0; t < NTHREADS; t++) begin : g_thr
    localparam logic [PC_W-1:0] RST = PC_W'(t) << (PC_W - 2);

    assign sel[t]  = tid_in == TID_W'(t);
    assign kill[t] = redirect_valid & (redirect_tid == TID_W'(t));
    assign hlt[t]  = halt_valid & (halt_tid == TID_W'(t));
    assign act[t]  = thread_en[t] & ~halted_w[t];
    // Halt outranks redirect; a halted thread ignores redirects.
    assign load[t] = kill[t] & ~halted_w[t] & ~hlt[t];
    assign inc[t]  = en & sel[t] & act[t] & ~kill[t] & ~hlt[t];

    thread_pc_reg #(
      .PC_W   (PC_W),
      .RST_PC (RST)
    ) u_pc (
      .clk_i     (clk),
      .rst_ni    (rst),
      .inc_i     (inc[t]),
      .load_i    (load[t]),
      .load_pc_i (redirect_pc),
      .halt_i    (hlt[t]),
      .pc_o      (pc_q[t]),
      .halted_o  (halted_w[t])
    );
  end

  assign imem_addr  = pc_q[tid_in];
  assign if_valid_d = act[tid_in] & ~kill[tid_in] & ~hlt[tid_in];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_q <= 1'b0;
      if_tid_q   <= '0;
      if_pc_q    <= '0;
    end else if (en) begin
      if_valid_q <= if_valid_d;
      if_tid_q   <= tid_in;
      if_pc_q    <= pc_q[tid_in];
    end
  end

  assign if_valid   = if_valid_q;
  assign if_tid     = if_tid_q;
  assign if_pc      = if_pc_q;
  assign halted     = halted_w;
  assign all_halted = &halted_w;

endmodule

// File: doc/thread_pc_fetch.md
Name: thread_pc_fetch

Overview:
- Per-thread program-counter file and instruction-fetch address stage for the 4-thread fine-grained multithreaded CPU.
- Sits directly downstream of the round-robin thread arbiter and consumes its 2-bit thread id every cycle.
- Drives the synchronous instruction-memory address. Registers the {valid, tid, pc} tag that travels alongside the instruction into decode.
- Accepts branch redirects and halts from later pipeline stages.

Parameters:
- PC_W, 9, instruction-memory word-address width.
- NTHREADS, 4, thread count (fixed at 4; TID_W = 2 follows from it).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (asserted at 0)
- en  input  1  pipeline advance enable
- tid_in  input  2  current thread id from the arbiter
- thread_en  input  4  per-thread run enable; bit t gates thread t
- redirect_valid  input  1  branch/jump taken in a later stage
- redirect_tid  input  2  thread being redirected
- redirect_pc  input  PC_W  new PC for redirect_tid
- halt_valid  input  1  halt instruction retired
- halt_tid  input  2  thread to halt
- imem_addr  output  PC_W  combinational: pc_q[tid_in]
- if_valid  output  1  registered: fetched slot carries a live instruction
- if_tid  output  2  registered thread tag
- if_pc  output  PC_W  registered PC of the fetched instruction
- halted  output  4  per-thread halted flags
- all_halted  output  1  &halted

Behaviour:
- State: pc_q[0..3] (PC_W each), halted[3:0], if_valid, if_tid, if_pc.
- Reset (rst=0, async): pc_q[t] = t << (PC_W-2), i.e. 0/128/256/384 for PC_W=9; halted=0; if_valid=0; if_tid=0; if_pc=0. Release is synchronous to clk.
- Thread active: act(t) = thread_en[t] & ~halted[t].
- imem_addr = pc_q[tid_in] (combinational). The BRAM returns data one cycle later, aligned with if_*.
- Posedge with en=1, where t = tid_in:
  - if_tid <= t
  - if_pc <= pc_q[t]
  - if_valid <= act(t) & ~kill, where kill = redirect_valid & (redirect_tid == t)
  - pc_q[t] <= pc_q[t] + 1 when act(t), modulo 2^PC_W (wraps from max to 0, no flag)
  - pc_q[t] holds when t is inactive.
- Posedge with en=0: if_* and the increment path hold.
- Redirect and halt are captured on every posedge regardless of en. Later stages drain independently.
- Redirect: pc_q[redirect_tid] <= redirect_pc.
  - Redirect beats the increment when redirect_tid == tid_in.
  - In that case the wrong-path fetch is squashed (if_valid = 0).
  - Redirect to a thread already halted (or halting the same cycle) is ignored.
- Halt: halted[halt_tid] <= 1.
  - Sticky; only reset clears it.
  - If halt_tid == tid_in in the same cycle, that slot's if_valid = 0 and its PC does not increment.
- Simultaneous redirect and halt on different threads: both take effect.
- Simultaneous redirect and halt on the same thread: halt wins, pc_q is unchanged.
- thread_en[t] = 0: slot t emits if_valid = 0 and its PC is frozen. Redirect/halt to t are still accepted (redirect unless halted).
- Latency: tid_in -> if_* is 1 cycle. Redirect is visible on imem_addr the next time that thread's slot comes around.
- Reset asserted mid-operation: all state returns to reset values immediately. The in-flight if_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - NTHREADS = 4, TID_W = 2, PC_W default
  - per-thread reset-PC function base_pc(t) = t << (PC_W-2)
  - tid typedef and the fetch-tag struct {valid, tid, pc}, shared with decode
- One natural sub-module: thread_pc_reg, a single-thread PC register with inc/load/hold controls and its halted bit, instantiated 4x. Select/kill logic stays in the top.

Test Plan:
- Reset, all thread_en = 1111, arbiter cycling 0..3 for 8 cycles -> if_pc sequence 0,128,256,384,1,129,257,385, if_valid = 1 throughout, if_tid = 0,1,2,3,0,...
- Redirect tid=2 to pc 0x1F0 in the same cycle tid_in=2 -> that slot if_valid = 0. Next tid=2 slot gives if_pc = 0x1F0, then 0x1F1.
- halt_valid tid=1 -> halted = 0010. Tid-1 slots thereafter give if_valid = 0 and pc_q[1] frozen. Redirect to tid 1 is ignored. Halting all four -> all_halted = 1.
- Force pc_q[3] to 511 via redirect, then fetch twice -> if_pc = 511 then 0 (wrap).
- en = 0 for 3 cycles while a redirect to tid 0 arrives -> if_* held, no increments. Redirect applied, so after en = 1 the tid-0 fetch returns the redirect PC.
- Assert rst = 0 asynchronously mid-stream (between edges) -> if_valid = 0 and all pc_q at base values before the next edge. Fetch resumes at 0/128/256/384.
